// File: rtl/serial_crypto_node.sv
// -----------------------------------------------------------------------------
// serial_crypto_node
//   Serial front end for a block enc/dec core. A frame opens when cs falls and
//   carries one mode bit, then the message and then the key, all MSB-first and
//   LANES bits per beat. The node presents the assembled words to the core,
//   pulses core_start, waits for core_done and then serialises the core result
//   back out on sdo. Raising cs before the result has been sent abandons the
//   frame.
//
//   Optional feature macro: SUBNODE_TIMEOUT_EN
//     When defined, WAIT gives up after TIMEOUT cycles without core_done. It
//     then sets err and skips TX. When undefined, err is tied low and WAIT
//     lasts until core_done or an abort.
//
//   Ports
//     in_clk          clock, rising edge
//     rst             asynchronous active-high reset
//     cs              frame select, active low
//     sdi[LANES]      serial data in
//     sdo[LANES]      serial result out
//     sdo_oe          sdo valid / drive enable
//     to_core_msg     message word to the core
//     to_core_key     key word to the core
//     to_core_mode    0 = encrypt, 1 = decrypt
//     core_start      one-cycle start pulse to the core
//     core_done       core result strobe
//     from_core_msg   core result
//     busy            frame in progress
//     data_done       high while the result is shifting out
//     err             core timeout flag
// -----------------------------------------------------------------------------
module serial_crypto_node #(
  parameter int NB      = 4,
  parameter int NK      = 8,
  parameter int LANES   = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                in_clk,
  input  logic                rst,
  input  logic                cs,
  input  logic [LANES-1:0]    sdi,
  output logic [LANES-1:0]    sdo,
  output logic                sdo_oe,
  output logic [32*NB-1:0]    to_core_msg,
  output logic [32*NK-1:0]    to_core_key,
  output logic                to_core_mode,
  output logic                core_start,
  input  logic                core_done,
  input  logic [32*NB-1:0]    from_core_msg,
  output logic                busy,
  output logic                data_done,
  output logic                err
);

  localparam int MSG_W     = 32 * NB;
  localparam int KEY_W     = 32 * NK;
  localparam int MSG_BEATS = MSG_W / LANES;
  localparam int KEY_BEATS = KEY_W / LANES;
  localparam int BEAT_MAX  = (MSG_BEATS > KEY_BEATS) ? MSG_BEATS : KEY_BEATS;
  // A single counter serves the beat phases and, when enabled, the WAIT timeout.
  localparam int CNT_MAX   = (BEAT_MAX > TIMEOUT) ? BEAT_MAX : TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_MODE = 3'd1,
    RX_MSG  = 3'd2,
    RX_KEY  = 3'd3,
    START   = 3'd4,
    WAIT    = 3'd5,
    TX      = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_rx_q, mode_rx_d;
  logic [MSG_W-1:0]   msg_sr_q, msg_sr_d;
  logic [KEY_W-1:0]   key_sr_q, key_sr_d;
  logic [MSG_W-1:0]   tx_sr_q, tx_sr_d;
  logic [LANES-1:0]   sdo_q, sdo_d;
  logic               sdo_oe_q, sdo_oe_d;
  logic               data_done_q, data_done_d;
  logic               busy_q, busy_d;
  logic [MSG_W-1:0]   core_msg_q, core_msg_d;
  logic [KEY_W-1:0]   core_key_q, core_key_d;
  logic               core_mode_q, core_mode_d;
  logic               core_start_q, core_start_d;
`ifdef SUBNODE_TIMEOUT_EN
  logic               err_q, err_d;
`endif

  logic               abortable_s;
  logic [MSG_W-1:0]   msg_shift_s;
  logic [KEY_W-1:0]   key_shift_s;
  logic [MSG_W-1:0]   tx_shift_s;

  // cs high only abandons a frame in the states that belong to an open frame.
  assign abortable_s = (state_q != IDLE) && (state_q != DONE);
  assign msg_shift_s = {msg_sr_q[MSG_W-LANES-1:0], sdi};
  assign key_shift_s = {key_sr_q[KEY_W-LANES-1:0], sdi};
  assign tx_shift_s  = {tx_sr_q[MSG_W-LANES-1:0], {LANES{1'b0}}};

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mode_rx_q    <= 1'b0;
      msg_sr_q     <= '0;
      key_sr_q     <= '0;
      tx_sr_q      <= '0;
      sdo_q        <= '0;
      sdo_oe_q     <= 1'b0;
      data_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      core_msg_q   <= '0;
      core_key_q   <= '0;
      core_mode_q  <= 1'b0;
      core_start_q <= 1'b0;
`ifdef SUBNODE_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_rx_q    <= mode_rx_d;
      msg_sr_q     <= msg_sr_d;
      key_sr_q     <= key_sr_d;
      tx_sr_q      <= tx_sr_d;
      sdo_q        <= sdo_d;
      sdo_oe_q     <= sdo_oe_d;
      data_done_q  <= data_done_d;
      busy_q       <= busy_d;
      core_msg_q   <= core_msg_d;
      core_key_q   <= core_key_d;
      core_mode_q  <= core_mode_d;
      core_start_q <= core_start_d;
`ifdef SUBNODE_TIMEOUT_EN
      err_q        <= err_d;
`endif
    end
  end

  // Next-state and next-output logic. Outputs are computed one edge ahead so
  // that they are registered and line up with the state they belong to.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_rx_d    = mode_rx_q;
    msg_sr_d     = msg_sr_q;
    key_sr_d     = key_sr_q;
    tx_sr_d      = tx_sr_q;
    sdo_d        = sdo_q;
    sdo_oe_d     = sdo_oe_q;
    data_done_d  = data_done_q;
    busy_d       = busy_q;
    core_msg_d   = core_msg_q;
    core_key_d   = core_key_q;
    core_mode_d  = core_mode_q;
    core_start_d = 1'b0;
`ifdef SUBNODE_TIMEOUT_EN
    err_d        = err_q;
`endif

    if (cs && abortable_s) begin
      // Abort: drop partial data and leave the words seen by the core untouched.
      // This branch takes priority over a simultaneous core_done.
      state_d     = IDLE;
      cnt_d       = '0;
      msg_sr_d    = '0;
      key_sr_d    = '0;
      tx_sr_d     = '0;
      sdo_d       = '0;
      sdo_oe_d    = 1'b0;
      data_done_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!cs) begin
            state_d  = RX_MODE;
            busy_d   = 1'b1;
            cnt_d    = '0;
            msg_sr_d = '0;
            key_sr_d = '0;
`ifdef SUBNODE_TIMEOUT_EN
            err_d    = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
        RX_MODE: begin
          mode_rx_d = sdi[0];
          cnt_d     = '0;
          state_d   = RX_MSG;
        end
        RX_MSG: begin
          msg_sr_d = msg_shift_s;
          if (cnt_q == CNT_W'(MSG_BEATS - 1)) begin
            cnt_d   = '0;
            state_d = RX_KEY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RX_KEY: begin
          key_sr_d = key_shift_s;
          if (cnt_q == CNT_W'(KEY_BEATS - 1)) begin
            // The last key beat is folded in here so that the core words and
            // the start pulse are already valid during the START cycle.
            cnt_d        = '0;
            state_d      = START;
            core_start_d = 1'b1;
            core_msg_d   = msg_sr_q;
            core_key_d   = key_shift_s;
            core_mode_d  = mode_rx_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        START: begin
          cnt_d   = '0;
          state_d = WAIT;
        end
        WAIT: begin
          if (core_done) begin
            // The first beat goes to sdo now; the shift register keeps the rest.
            sdo_d       = from_core_msg[MSG_W-1 -: LANES];
            tx_sr_d     = {from_core_msg[MSG_W-LANES-1:0], {LANES{1'b0}}};
            sdo_oe_d    = 1'b1;
            data_done_d = 1'b1;
            cnt_d       = '0;
            state_d     = TX;
          end else begin
`ifdef SUBNODE_TIMEOUT_EN
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
              err_d   = 1'b1;
              busy_d  = 1'b0;
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
`else
            state_d = WAIT;
`endif
          end
        end
        TX: begin
          if (cnt_q == CNT_W'(MSG_BEATS - 1)) begin
            sdo_d       = '0;
            sdo_oe_d    = 1'b0;
            data_done_d = 1'b0;
            busy_d      = 1'b0;
            tx_sr_d     = '0;
            cnt_d       = '0;
            state_d     = DONE;
          end else begin
            sdo_d   = tx_sr_q[MSG_W-1 -: LANES];
            tx_sr_d = tx_shift_s;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // Only a return of cs to high re-arms the node, so one low period
          // carries at most one frame.
          if (cs) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d     = IDLE;
          cnt_d       = '0;
          sdo_d       = '0;
          sdo_oe_d    = 1'b0;
          data_done_d = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  assign sdo          = sdo_q;
  assign sdo_oe       = sdo_oe_q;
  assign data_done    = data_done_q;
  assign busy         = busy_q;
  assign to_core_msg  = core_msg_q;
  assign to_core_key  = core_key_q;
  assign to_core_mode = core_mode_q;
  assign core_start   = core_start_q;
`ifdef SUBNODE_TIMEOUT_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_serial_crypto_node.sv
// -----------------------------------------------------------------------------
// tb_serial_crypto_node
//   Directed bench with two instances: a 1-lane node and a 4-lane node. Both
//   share a bench core model on core_done/from_core_msg. An idle node ignores
//   core_done, so sharing the core model is harmless.
// -----------------------------------------------------------------------------
module tb_serial_crypto_node;

  localparam logic [127:0] MSG  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RES  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] MSG2 = 128'hdeadbeef0123456789abcdef55aa33cc;
  localparam logic [255:0] KEY2 = 256'hf0e1d2c3b4a5968778695a4b3c2d1e0f00ff11ee22dd33cc44bb55aa66997788;
  localparam logic [127:0] RES2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic         clk = 1'b0;
  logic         rst;
  logic         cs_drv;
  logic [3:0]   sdi_drv;
  logic         sel;
  logic         core_done;
  logic [127:0] from_core;

  logic         cs1, cs4;
  logic [0:0]   sdo1;
  logic [3:0]   sdo4;
  logic         oe1, oe4, mode1, mode4, start1, start4;
  logic         busy1, busy4, dd1, dd4, err1, err4;
  logic [127:0] msg1, msg4;
  logic [255:0] key1, key4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign cs1 = sel ? 1'b1 : cs_drv;
  assign cs4 = sel ? cs_drv : 1'b1;

  serial_crypto_node #(.NB(4), .NK(8), .LANES(1), .TIMEOUT(16)) dut1 (
    .in_clk(clk), .rst(rst), .cs(cs1), .sdi(sdi_drv[0:0]), .sdo(sdo1), .sdo_oe(oe1),
    .to_core_msg(msg1), .to_core_key(key1), .to_core_mode(mode1), .core_start(start1),
    .core_done(core_done), .from_core_msg(from_core), .busy(busy1), .data_done(dd1), .err(err1)
  );

  serial_crypto_node #(.NB(4), .NK(8), .LANES(4), .TIMEOUT(16)) dut4 (
    .in_clk(clk), .rst(rst), .cs(cs4), .sdi(sdi_drv), .sdo(sdo4), .sdo_oe(oe4),
    .to_core_msg(msg4), .to_core_key(key4), .to_core_mode(mode4), .core_start(start4),
    .core_done(core_done), .from_core_msg(from_core), .busy(busy4), .data_done(dd4), .err(err4)
  );

  // Observation view of whichever instance is selected.
  wire [3:0]   sdo_m   = sel ? sdo4 : {3'b000, sdo1};
  wire         oe_m    = sel ? oe4 : oe1;
  wire         start_m = sel ? start4 : start1;
  wire         busy_m  = sel ? busy4 : busy1;
  wire         dd_m    = sel ? dd4 : dd1;
  wire         err_m   = sel ? err4 : err1;
  wire         mode_m  = sel ? mode4 : mode1;
  wire [127:0] msg_m   = sel ? msg4 : msg1;
  wire [255:0] key_m   = sel ? key4 : key1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one frame on the selected instance. abort_kb >= 0 raises cs after that
  // many key beats; rst_tx >= 0 pulses rst during that TX beat; done_en = 0
  // lets WAIT run without a core_done.
  task automatic run_frame(input int lanes, input logic mode, input logic [127:0] msg,
                           input logic [255:0] key, input logic [127:0] res,
                           input int abort_kb, input int rst_tx, input bit done_en,
                           output int s_cyc, output int s_cnt);
    int mb;
    int kb;
    int cyc;
    logic [127:0] got;
    logic dd_ok;
    logic oe_seen;
    mb = 128 / lanes;
    kb = 256 / lanes;
    s_cnt = 0;
    s_cyc = -1;
    got = '0;
    dd_ok = 1'b1;
    oe_seen = 1'b0;
    sel = (lanes == 4);
    @(negedge clk);
    cs_drv = 1'b0;
    sdi_drv = 4'h0;
    @(negedge clk);
    cyc = 0;
    chk("busy_rx_mode", busy_m, 1'b1);
    sdi_drv = {3'b101, mode};
    for (int i = 0; i < mb; i++) begin
      @(negedge clk);
      cyc++;
      if (start_m) begin s_cnt++; s_cyc = cyc; end
      sdi_drv = (lanes == 1) ? {3'b000, msg[127-i]} : msg[127-4*i -: 4];
    end
    for (int i = 0; i < kb; i++) begin
      @(negedge clk);
      cyc++;
      if (start_m) begin s_cnt++; s_cyc = cyc; end
      if (i == abort_kb) begin
        cs_drv = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy_m, 1'b0);
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          if (start_m) begin s_cnt++; s_cyc = cyc; end
        end
        return;
      end
      sdi_drv = (lanes == 1) ? {3'b000, key[255-i]} : key[255-4*i -: 4];
    end
    @(negedge clk);
    cyc++;
    if (start_m) begin s_cnt++; s_cyc = cyc; end
    chk("to_core_msg", msg_m, msg);
    chk("to_core_key", key_m, key);
    chk("to_core_mode", mode_m, mode);
    if (done_en) begin
      for (int w = 1; w <= 12; w++) begin
        @(negedge clk);
        cyc++;
        if (start_m) begin s_cnt++; s_cyc = cyc; end
        oe_seen = oe_seen | oe_m;
        if (w == 12) begin
          core_done = 1'b1;
          from_core = res;
        end
      end
      chk("oe_during_wait", oe_seen, 1'b0);
      for (int b = 0; b < mb; b++) begin
        @(negedge clk);
        cyc++;
        core_done = 1'b0;
        if (start_m) begin s_cnt++; s_cyc = cyc; end
        if (b == rst_tx) begin
          chk("sdo_before_rst", sdo_m, (lanes == 1) ? {3'b000, res[127-b]} : res[127-4*b -: 4]);
          #2 rst = 1'b1;
          #1;
          chk("rst_outputs", {sdo_m, oe_m, mode_m, start_m, busy_m, dd_m, err_m}, 256'h0);
          chk("rst_core_msg", msg_m, 128'h0);
          chk("rst_core_key", key_m, 256'h0);
          cs_drv = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        got = (lanes == 1) ? {got[126:0], sdo_m[0]} : {got[123:0], sdo_m};
        dd_ok = dd_ok & dd_m & oe_m;
      end
      chk("tx_result", got, res);
      chk("tx_dd_oe_high", dd_ok, 1'b1);
      @(negedge clk);
      chk("done_outputs", {sdo_m, oe_m, dd_m, busy_m}, 7'h00);
      // Hold cs low in DONE and offer a stray core_done: nothing may restart.
      core_done = 1'b1;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (start_m) begin s_cnt++; s_cyc = cyc; end
      end
      core_done = 1'b0;
      chk("done_hold", {oe_m, busy_m}, 2'b00);
      cs_drv = 1'b1;
      @(negedge clk);
    end else begin
`ifdef SUBNODE_TIMEOUT_EN
      for (int w = 1; w <= 16; w++) begin
        @(negedge clk);
        oe_seen = oe_seen | oe_m;
      end
      chk("err_before_timeout", err_m, 1'b0);
      @(negedge clk);
      chk("err_at_timeout", err_m, 1'b1);
      chk("timeout_oe_busy", {oe_seen, oe_m, busy_m}, 3'b000);
      cs_drv = 1'b1;
      @(negedge clk);
      chk("err_held_idle", err_m, 1'b1);
      cs_drv = 1'b0;
      @(negedge clk);
      chk("err_cleared", err_m, 1'b0);
      cs_drv = 1'b1;
      @(negedge clk);
`else
      for (int w = 0; w < 80; w++) begin
        @(negedge clk);
        oe_seen = oe_seen | oe_m | err_m;
      end
      chk("wait_indefinite", {busy_m, oe_seen}, 2'b10);
      // Abort and core_done in the same cycle: the abort must win.
      cs_drv = 1'b1;
      core_done = 1'b1;
      from_core = res;
      @(negedge clk);
      core_done = 1'b0;
      chk("abort_vs_done", {busy_m, oe_m, dd_m}, 3'b000);
      @(negedge clk);
      chk("abort_vs_done_late", oe_m, 1'b0);
`endif
    end
  endtask

  initial begin
    int sc;
    int sn;
    rst = 1'b1;
    cs_drv = 1'b1;
    sdi_drv = 4'h0;
    sel = 1'b0;
    core_done = 1'b0;
    from_core = 128'h0;
    #12;
    chk("reset_dut1", {sdo1, oe1, mode1, start1, busy1, dd1, err1, msg1}, 256'h0);
    chk("reset_dut1_key", key1, 256'h0);
    chk("reset_dut4", {sdo4, oe4, mode4, start4, busy4, dd4, err4, msg4}, 256'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Encrypt, one lane.
    run_frame(1, 1'b0, MSG, KEY, RES, -1, -1, 1'b1, sc, sn);
    chk("enc_start_cycle", sc, 385);
    chk("enc_start_count", sn, 1);

    // Abort after 100 key bits: core words keep the encrypt frame.
    run_frame(1, 1'b1, MSG2, KEY2, RES2, 100, -1, 1'b1, sc, sn);
    chk("abort_start_count", sn, 0);
    chk("abort_core_msg", msg1, MSG);
    chk("abort_core_key", key1, KEY);
    chk("abort_core_mode", mode1, 1'b0);

    // Decrypt, four lanes.
    run_frame(4, 1'b1, MSG, KEY, MSG, -1, -1, 1'b1, sc, sn);
    chk("dec_start_cycle", sc, 97);
    chk("dec_start_count", sn, 1);

    // Reset during TX beat 50, then a clean frame.
    run_frame(1, 1'b1, MSG2, KEY2, RES2, -1, 50, 1'b1, sc, sn);
    run_frame(1, 1'b1, MSG2, KEY2, RES2, -1, -1, 1'b1, sc, sn);
    chk("post_rst_start_cycle", sc, 385);
    chk("post_rst_start_count", sn, 1);

    // Core never answers.
    run_frame(1, 1'b0, MSG, KEY, RES, -1, -1, 1'b0, sc, sn);
    chk("nodone_start_count", sn, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
